// File: rtl/bus_sequencer_pkg.sv
// Shared definitions for the bus sequencer: opcodes, state encoding and instruction field layout.
package bus_sequencer_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_T1   = 2'd1;
    localparam logic [1:0] ST_T2   = 2'd2;
    localparam logic [1:0] ST_T3   = 2'd3;

    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

    typedef logic [8:0] instr_t;

    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

endpackage

// File: rtl/bus_sequencer_decode.sv
// Moore decode of {state, IR} into every datapath control, done and err.
module seq_decode
    import bus_sequencer_pkg::*;
(
    input  logic [1:0] state,
    input  instr_t     ir,
    output logic [7:0] reg_in,
    output logic [7:0] reg_out,
    output logic       extern_en,
    output logic       a_in,
    output logic       b_in,
    output logic       g_in,
    output logic       g_out,
    output logic       h_in,
    output logic       h_out,
    output logic       add_sub,
    output logic       done,
    output logic       err
);

    logic [2:0] op_s;
    logic [7:0] rx_oh_s;
    logic [7:0] ry_oh_s;

    assign op_s    = ir[OP_HI:OP_LO];
    assign rx_oh_s = reg_onehot(ir[RX_HI:RX_LO]);
    assign ry_oh_s = reg_onehot(ir[RY_HI:RY_LO]);

    // Step table: each state enables exactly one bus driver at most.
    always_comb begin
        reg_in    = 8'd0;
        reg_out   = 8'd0;
        extern_en = 1'b0;
        a_in      = 1'b0;
        b_in      = 1'b0;
        g_in      = 1'b0;
        g_out     = 1'b0;
        h_in      = 1'b0;
        h_out     = 1'b0;
        add_sub   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            ST_T1: begin
                case (op_s)
                    OP_LOAD: begin
                        extern_en = 1'b1;
                        reg_in    = rx_oh_s;
                        done      = 1'b1;
                    end
                    OP_MOV: begin
                        reg_out = ry_oh_s;
                        reg_in  = rx_oh_s;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_out = rx_oh_s;
                        a_in    = 1'b1;
                    end
                    OP_XOR: begin
                        reg_out = rx_oh_s;
                        b_in    = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                        err  = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                case (op_s)
                    OP_ADD, OP_SUB: begin
                        reg_out = ry_oh_s;
                        g_in    = 1'b1;
                        add_sub = ir[OP_LO];
                    end
                    OP_XOR: begin
                        reg_out = ry_oh_s;
                        h_in    = 1'b1;
                    end
                    default: begin
                        reg_out = 8'd0;
                    end
                endcase
            end
            ST_T3: begin
                case (op_s)
                    OP_ADD, OP_SUB: begin
                        g_out  = 1'b1;
                        reg_in = rx_oh_s;
                        done   = 1'b1;
                    end
                    OP_XOR: begin
                        h_out  = 1'b1;
                        reg_in = rx_oh_s;
                        done   = 1'b1;
                    end
                    default: begin
                        reg_in = 8'd0;
                    end
                endcase
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// Bus control sequencer: state register, instruction register and valid/ready handshake.
// Optional build macro SEQ_BACK_TO_BACK_EN lets a new instruction be accepted in the final step.
module bus_sequencer
    import bus_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [7:0] reg_in,
    output logic [7:0] reg_out,
    output logic       extern_en,
    output logic       a_in,
    output logic       b_in,
    output logic       g_in,
    output logic       g_out,
    output logic       h_in,
    output logic       h_out,
    output logic       add_sub,
    output logic       done,
    output logic       err
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    instr_t     ir_r;
    logic       ready_s;
    logic       accept_s;

    seq_decode u_decode (
        .state     (state_r),
        .ir        (ir_r),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .extern_en (extern_en),
        .a_in      (a_in),
        .b_in      (b_in),
        .g_in      (g_in),
        .g_out     (g_out),
        .h_in      (h_in),
        .h_out     (h_out),
        .add_sub   (add_sub),
        .done      (done),
        .err       (err)
    );

    // Ready is held low while reset is asserted so nothing is accepted during reset.
    always_comb begin
`ifdef SEQ_BACK_TO_BACK_EN
        ready_s = (state_r == ST_IDLE) || done;
`else
        ready_s = (state_r == ST_IDLE);
`endif
        instr_ready = rst & ready_s;
        accept_s    = instr_valid & instr_ready;
    end

    // Next-state: finishing steps return to IDLE or chain straight into T1.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (state_r == ST_IDLE || done) begin
            state_nxt_s = accept_s ? ST_T1 : ST_IDLE;
        end else if (state_r == ST_T1) begin
            state_nxt_s = ST_T2;
        end else if (state_r == ST_T2) begin
            state_nxt_s = ST_T3;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // State and instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ir_r    <= 9'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                ir_r <= instr;
            end
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus a random stream against a step-table model.
module tb_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] instr = 9'd0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] reg_in, reg_out;
    logic       extern_en, a_in, b_in, g_in, g_out, h_in, h_out, add_sub, done, err;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEQ_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    localparam logic [9:0] F_EXT = 10'b1000000000;
    localparam logic [9:0] F_A   = 10'b0100000000;
    localparam logic [9:0] F_B   = 10'b0010000000;
    localparam logic [9:0] F_GI  = 10'b0001000000;
    localparam logic [9:0] F_GO  = 10'b0000100000;
    localparam logic [9:0] F_HI  = 10'b0000010000;
    localparam logic [9:0] F_HO  = 10'b0000001000;
    localparam logic [9:0] F_AS  = 10'b0000000100;
    localparam logic [9:0] F_DN  = 10'b0000000010;
    localparam logic [9:0] F_ER  = 10'b0000000001;

    logic [25:0] ctl;
    assign ctl = {reg_in, reg_out, extern_en, a_in, b_in, g_in, g_out, h_in, h_out, add_sub, done, err};

    bus_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .reg_in      (reg_in),
        .reg_out     (reg_out),
        .extern_en   (extern_en),
        .a_in        (a_in),
        .b_in        (b_in),
        .g_in        (g_in),
        .g_out       (g_out),
        .h_in        (h_in),
        .h_out       (h_out),
        .add_sub     (add_sub),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] pk(input logic [7:0] ri, input logic [7:0] ro, input logic [9:0] f);
        return {ri, ro, f};
    endfunction

    function automatic int n_steps(input logic [8:0] ins);
        logic [2:0] op;
        op = ins[8:6];
        return (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3 : 1;
    endfunction

    // Reference: controls for step s (1-based) of instruction ins, from the opcode table.
    function automatic logic [25:0] exp_ctl(input logic [8:0] ins, input int s);
        logic [2:0] op;
        logic [7:0] ohx, ohy;
        op  = ins[8:6];
        ohx = 8'd1 << ins[5:3];
        ohy = 8'd1 << ins[2:0];
        if (op == 3'd0) return pk(ohx, 8'd0, F_EXT | F_DN);
        if (op == 3'd1) return pk(ohx, ohy, F_DN);
        if (op >= 3'd5) return pk(8'd0, 8'd0, F_DN | F_ER);
        if (s == 1) return pk(8'd0, ohx, (op == 3'd4) ? F_B : F_A);
        if (s == 2) return (op == 3'd4) ? pk(8'd0, ohy, F_HI)
                                        : pk(8'd0, ohy, F_GI | ((op == 3'd3) ? F_AS : 10'd0));
        return pk(ohx, 8'd0, ((op == 3'd4) ? F_HO : F_GO) | F_DN);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: ctl=%h ready=%b required ctl=0 ready=0", ctl, instr_ready);
        end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ctl=%h ready=%b required ctl=0 ready=1", ctl, instr_ready);
        end
    endtask

    task automatic test_load();
        tick();
        instr = 9'b000_011_000;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (ctl !== pk(8'h08, 8'h00, F_EXT | F_DN)) begin
            n_fail++;
            $display("FAIL load_t1: ctl=%h required %h", ctl, pk(8'h08, 8'h00, F_EXT | F_DN));
        end
        tick();
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_after: ctl=%h ready=%b required ctl=0 ready=1", ctl, instr_ready);
        end
    endtask

    task automatic test_sub();
        instr = 9'b011_001_110;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (ctl !== pk(8'h00, 8'h02, F_A) || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_t1: ctl=%h ready=%b required %h ready=0", ctl, instr_ready, pk(8'h00, 8'h02, F_A));
        end
        tick();
        n_checks++;
        if (ctl !== pk(8'h00, 8'h40, F_GI | F_AS) || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_t2: ctl=%h ready=%b required %h ready=0", ctl, instr_ready, pk(8'h00, 8'h40, F_GI | F_AS));
        end
        tick();
        n_checks++;
        if (ctl !== pk(8'h02, 8'h00, F_GO | F_DN) || instr_ready !== B2B) begin
            n_fail++;
            $display("FAIL sub_t3: ctl=%h ready=%b required %h ready=%b", ctl, instr_ready, pk(8'h02, 8'h00, F_GO | F_DN), B2B);
        end
        tick();
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_after: ctl=%h ready=%b required ctl=0 ready=1", ctl, instr_ready);
        end
    endtask

    task automatic test_back_to_back();
        instr = 9'b100_111_111;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (ctl !== pk(8'h00, 8'h80, F_B)) begin
            n_fail++;
            $display("FAIL xor_t1: ctl=%h required %h", ctl, pk(8'h00, 8'h80, F_B));
        end
        tick();
        n_checks++;
        if (ctl !== pk(8'h00, 8'h80, F_HI)) begin
            n_fail++;
            $display("FAIL xor_t2: ctl=%h required %h", ctl, pk(8'h00, 8'h80, F_HI));
        end
        tick();
        n_checks++;
        if (ctl !== pk(8'h80, 8'h00, F_HO | F_DN)) begin
            n_fail++;
            $display("FAIL xor_t3: ctl=%h required %h", ctl, pk(8'h80, 8'h00, F_HO | F_DN));
        end
        instr = 9'b001_000_111;
        instr_valid = 1'b1;
        tick();
        if (!B2B) begin
            n_checks++;
            if (ctl !== 26'd0 || instr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_gap: ctl=%h ready=%b required ctl=0 ready=1", ctl, instr_ready);
            end
            tick();
        end
        instr_valid = 1'b0;
        n_checks++;
        if (ctl !== pk(8'h01, 8'h80, F_DN)) begin
            n_fail++;
            $display("FAIL mov_t1: ctl=%h required %h", ctl, pk(8'h01, 8'h80, F_DN));
        end
        tick();
    endtask

    task automatic test_illegal();
        instr = 9'b110_010_101;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (ctl !== pk(8'h00, 8'h00, F_DN | F_ER)) begin
            n_fail++;
            $display("FAIL illegal: ctl=%h required %h", ctl, pk(8'h00, 8'h00, F_DN | F_ER));
        end
        tick();
        n_checks++;
        if (ctl !== 26'd0) begin
            n_fail++;
            $display("FAIL illegal_after: ctl=%h required 0", ctl);
        end
    endtask

    task automatic test_async_reset();
        instr = 9'b010_010_011;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        n_checks++;
        if (ctl !== pk(8'h00, 8'h08, F_GI)) begin
            n_fail++;
            $display("FAIL add_t2: ctl=%h required %h", ctl, pk(8'h00, 8'h08, F_GI));
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_kill: ctl=%h ready=%b required ctl=0 ready=0", ctl, instr_ready);
        end
        tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 26'd0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: ctl=%h ready=%b required ctl=0 ready=1", ctl, instr_ready);
        end
        tick();
        n_checks++;
        if (ctl !== 26'd0) begin
            n_fail++;
            $display("FAIL async_no_done: ctl=%h required 0", ctl);
        end
    endtask

    task automatic test_random();
        logic [8:0] cur;
        int         step;
        int         accepted;
        int         dones;
        int         cyc;
        logic [25:0] exp;
        logic       exp_rdy;
        cur = 9'd0;
        step = 0;
        accepted = 0;
        dones = 0;
        cyc = 0;
        while ((accepted < 1000 || step != 0) && cyc < 20000) begin
            exp     = (step == 0) ? 26'd0 : exp_ctl(cur, step);
            exp_rdy = (step == 0) || (B2B && step == n_steps(cur));
            n_checks++;
            if (ctl !== exp || instr_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_cycle%0d: ctl=%h ready=%b required %h ready=%b", cyc, ctl, instr_ready, exp, exp_rdy);
            end
            n_checks++;
            if ($countones({reg_out, extern_en, g_out, h_out}) > 1 || $countones(reg_in) > 1) begin
                n_fail++;
                $display("FAIL rand_exclusive: reg_out=%h ext=%b g_out=%b h_out=%b reg_in=%h required at most one driver",
                         reg_out, extern_en, g_out, h_out, reg_in);
            end
            if (done === 1'b1) dones++;
            instr       = 9'($urandom_range(0, 511));
            instr_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            if (step != 0 && step < n_steps(cur)) begin
                step++;
            end else if (instr_valid && exp_rdy) begin
                cur = instr;
                step = 1;
                accepted++;
            end else begin
                step = 0;
            end
            tick();
            cyc++;
        end
        instr_valid = 1'b0;
        n_checks++;
        if (cyc >= 20000) begin
            n_fail++;
            $display("FAIL rand_timeout: cycles=%0d required under 20000", cyc);
        end
        n_checks++;
        if (dones !== accepted) begin
            n_fail++;
            $display("FAIL rand_done_count: done=%0d required %0d", dones, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sub();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Control sequencer for the shared 16-bit bus datapath (eight general registers R0–R7, A/G add-subtract unit, B/H XOR unit, external data tri-buffer). It accepts one instruction at a time over a valid/ready handshake and drives every register-in, tri-buffer-out and ALU-mode control for the correct number of bus steps. It replaces the free-running two-bit step counter with an explicit state machine that guarantees exactly one bus driver per cycle and signals completion.

## Interface
- No parameters; widths fixed by the datapath (8 registers, 3-bit register index).
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- instr  in  9  instruction: [8:6] opcode, [5:3] Rx (destination/first operand), [2:0] Ry (source/second operand)
- instr_valid  in  1  instr is presented
- instr_ready  out  1  sequencer accepts instr this cycle
- reg_in  out  8  one-hot load enable for R0–R7
- reg_out  out  8  one-hot tri-buffer enable for R0–R7
- extern_en  out  1  external data tri-buffer enable
- a_in, b_in  out  1  A / B operand register load
- g_in, g_out  out  1  G register load / tri-buffer enable
- h_in, h_out  out  1  H register load / tri-buffer enable
- add_sub  out  1  ALU mode: 0 add, 1 subtract
- done  out  1  single-cycle pulse in final step of an instruction
- err  out  1  single-cycle pulse when an illegal opcode is retired

## Operation
- Opcodes: 000 LOAD Rx←data; 001 MOV Rx←Ry; 010 ADD Rx←Rx+Ry; 011 SUB Rx←Rx−Ry; 100 XOR Rx←Rx^Ry; 101–111 illegal.
- States: IDLE, T1, T2, T3. Handshake completes on instr_valid && instr_ready; instr captured into internal IR on that edge; state → T1.
- LOAD, T1: extern_en, reg_in[Rx], done.
- MOV, T1: reg_out[Ry], reg_in[Rx], done.
- ADD/SUB, T1: reg_out[Rx], a_in. T2: reg_out[Ry], g_in, add_sub = opcode[0]. T3: g_out, reg_in[Rx], done.
- XOR, T1: reg_out[Rx], b_in. T2: reg_out[Ry], h_in. T3: h_out, reg_in[Rx], done.
- Illegal, T1: no enables, done and err.
- After final step: IDLE, or T1 of next instruction if one was accepted (see Configuration).
- Rx == Ry legal for all ops (MOV self is a no-op transfer; SUB yields 0).
- Invariant: at most one of reg_out[*], extern_en, g_out, h_out high in any cycle; reg_in at most one-hot. add_sub low outside T2 of SUB.
- All control outputs are decoded from state and IR only (Moore); instr_valid never affects controls in the same cycle.

## Timing
- Reset (asynchronous, active-low): state IDLE, IR = 0, all outputs 0 except instr_ready = 1 once reset deasserts. Assertion mid-instruction kills all enables immediately; the partial instruction is abandoned, no done.
- Accept at edge k → T1 during cycle k+1. LOAD/MOV/illegal: done in cycle k+1. ALU ops: done in cycle k+3.
- instr_ready high in IDLE; low in T1/T2 of multi-step ops and in single-step T1 unless back-to-back is enabled.
- instr held with instr_valid low is ignored; valid may drop without acceptance.

## Configuration
- SEQ_BACK_TO_BACK_EN defined: instr_ready also high during the final step (the done cycle); an instruction accepted there starts T1 on the next cycle with no IDLE gap. Sustained throughput: 1 cycle for LOAD/MOV, 3 cycles for ALU ops.
- Undefined: instr_ready high only in IDLE; every instruction is followed by one IDLE cycle.

## Structure
- Shared package: opcode constants (OP_LOAD … OP_XOR), state encoding, instruction field offsets.
- One sub-module: seq_decode — combinational decode of {state, IR} into all control outputs, done and err; bus_sequencer keeps state register, IR and handshake.

## Test plan
- LOAD R3 (instr 000_011_000), valid in IDLE → cycle after accept: extern_en=1, reg_in=0x08, done=1; next cycle all zero, instr_ready=1.
- SUB R1,R6 (011_001_110) → T1 reg_out=0x02,a_in; T2 reg_out=0x40,g_in,add_sub=1; T3 g_out,reg_in=0x02,done; exactly 3 cycles.
- XOR R7,R7 then MOV R0,R7 back-to-back with SEQ_BACK_TO_BACK_EN → MOV accepted in XOR's T3, MOV T1 (reg_out=0x80, reg_in=0x01) the following cycle; without macro one IDLE cycle between.
- Opcode 110 → one cycle with done=1, err=1, all enables 0.
- rst low during T2 of ADD → all outputs 0 asynchronously; after release, IDLE, instr_ready=1, no done pulse.
- Random instruction stream (1000 ops) → driver-exclusivity and one-hot reg_in assertions never fire; done count equals accepted count.
